// File: rtl/mux4_arb_pkg.sv
// Shared types, sizes and helpers for the mux4 round-robin arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational round-robin search: first set bit of (req & mask) scanning
// upward from ptr, wrapping 3->0.
module rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] masked;
    logic [SEL_W-1:0]   cand;

    assign masked = req & mask;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan from the farthest offset down so the nearest hit to ptr wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (masked[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4->1 mux, with a hold limit.
// Build option MUX4_ARB_PRIO_EN: source 0 wins every arbitration point it takes part in.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               valid
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    arb_state_t         state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0]   sel_nxt;

    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   winner;
    logic               take;
    logic               go_idle;

    // While granted, the owner is excluded so the search only sees contenders.
    assign pick_mask = (state == GRANT) ? ~onehot(sel) : '1;

    rr_pick u_pick (
        .req   (req),
        .mask  (pick_mask),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef MUX4_ARB_PRIO_EN
    assign winner = (req[0] && pick_mask[0]) ? '0 : pick_idx;
`else
    assign winner = pick_idx;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            sel      <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        grant_nxt = grant;
        sel_nxt   = sel;
        take      = 1'b0;
        go_idle   = 1'b0;

        case (state)
            IDLE: take = pick_found;
            GRANT: begin
                if (!req[sel]) begin
                    take    = pick_found;
                    go_idle = !pick_found;
                end else begin
                    take = pick_found && (hold_cnt == HOLD_LIMIT);
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (take) begin
            state_nxt = GRANT;
            grant_nxt = onehot(winner);
            sel_nxt   = winner;
            ptr_nxt   = winner + SEL_W'(1);
            hold_nxt  = '0;
        end else if (go_idle) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            hold_nxt  = '0;
        end else if (state == GRANT && hold_cnt != HOLD_LIMIT) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
        end
    end

    always_comb begin
        valid = |grant;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (MAX_HOLD = 8).
// Honours MUX4_ARB_PRIO_EN for the one vector whose outcome depends on it.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;

    int n_total;
    int n_pass;

    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] s);
        check({tag, ".grant"}, 8'(grant), 8'(g));
        check({tag, ".sel"},   8'(sel),   8'(s));
        check({tag, ".valid"}, 8'(valid), 8'(|g));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        req     = 4'b0000;

        // Single requester keeps the mux with nobody else waiting.
        do_reset();
        expect_grant("reset", 4'b0000, 2'd0);
        req = 4'b0100;
        tick();
        expect_grant("single_first", 4'b0100, 2'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            expect_grant($sformatf("single_hold%0d", k), 4'b0100, 2'd2);
        end

        // Back-to-back rotation as each owner releases.
        do_reset();
        req = 4'b1111;
        tick();
        expect_grant("rot0", 4'b0001, 2'd0);
        req = 4'b1110;
        tick();
        expect_grant("rot1", 4'b0010, 2'd1);
        req = 4'b1100;
        tick();
        expect_grant("rot2", 4'b0100, 2'd2);
        req = 4'b1000;
        tick();
        expect_grant("rot3", 4'b1000, 2'd3);
        req = 4'b0000;
        tick();
        expect_grant("rot_idle", 4'b0000, 2'd3);

        // Hold limit forces alternation every 8 cycles.
        do_reset();
        req = 4'b0011;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) begin
                tick();
                if (r % 2 == 0) expect_grant($sformatf("hold_r%0d_c%0d", r, k), 4'b0001, 2'd0);
                else            expect_grant($sformatf("hold_r%0d_c%0d", r, k), 4'b0010, 2'd1);
            end
        end

        // Pointer wraps from 3 back to 0.
        do_reset();
        req = 4'b1000;
        tick();
        expect_grant("wrap_own3", 4'b1000, 2'd3);
        req = 4'b0011;
        tick();
        expect_grant("wrap_next", 4'b0001, 2'd0);

        // Reset asserted while a grant is active.
        do_reset();
        req = 4'b1111;
        tick();
        expect_grant("rst_mid_a", 4'b0001, 2'd0);
        tick();
        expect_grant("rst_mid_b", 4'b0001, 2'd0);
        rst = 1'b1;
        tick();
        expect_grant("rst_mid_drop", 4'b0000, 2'd0);
        rst = 1'b0;
        tick();
        expect_grant("rst_mid_after", 4'b0001, 2'd0);

        // Release by owner 2 with req=1011: priority build favours source 0.
        do_reset();
        req = 4'b0100;
        tick();
        expect_grant("prio_own2", 4'b0100, 2'd2);
        req = 4'b1011;
        tick();
`ifdef MUX4_ARB_PRIO_EN
        expect_grant("prio_release", 4'b0001, 2'd0);
`else
        expect_grant("prio_release", 4'b1000, 2'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing the 4->1 data mux (mux4) between four requesters.
- Produces a registered one-hot grant and the matching 2-bit sel that drives mux4 directly.
- Grants persist while the owner keeps requesting, subject to a hold limit that forces rotation when others are waiting.
- Sits between requester logic and the mux4 instance in the datapath.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the mux while another request is pending. Legal range 2..255.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- req, input, 4, request per source; bit i corresponds to mux input d_i.
- grant, output, 4, one-hot grant, registered; all zero when idle.
- sel, output, 2, mux4 select, registered; equals the index of the set grant bit; holds its last value when idle.
- valid, output, 1, high while any grant is asserted (OR of grant).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: grant=0000, sel=00, valid=0, state=IDLE, ptr=0, hold_cnt=0. Reset mid-grant drops grant the next edge regardless of req.
- ptr is the round-robin search start, 0..3. Winner is the first set req bit scanning ptr, ptr+1, ... modulo 4 (wraps 3->0).
- IDLE state:
  - If req != 0: load grant = onehot(winner), sel = winner, ptr = winner+1 mod 4, hold_cnt=0, go to GRANT.
  - Latency is 1 cycle from req to grant.
  - If req == 0: stay in IDLE.
- GRANT state, with owner = sel:
  - Release: req[owner]=0. Re-arbitrate this cycle over the remaining requests (owner excluded). If any, grant the winner on the next edge (back-to-back, no idle bubble); else go to IDLE with grant=0000.
  - Preempt: req[owner]=1 AND hold_cnt==MAX_HOLD-1 AND any other req set. Grant the winner among the others on the next edge; hold_cnt=0.
  - Otherwise: keep the grant; hold_cnt increments, saturating at MAX_HOLD-1.
  - If no other request is pending, the owner keeps the grant indefinitely.
- On every new grant: ptr = new owner+1 mod 4, hold_cnt=0.
- Invariants:
  - grant is always zero or one-hot.
  - sel is consistent with grant.
  - A change of grant between two owners takes exactly one edge; no overlap.
- Simultaneous requests: resolved purely by ptr order. No requester waits more than 3*MAX_HOLD+3 cycles while continuously requesting.
- req may change any cycle; it is sampled only at clk edges.

Optional Feature:
- Macro MUX4_ARB_PRIO_EN.
- Defined: req[0] is high priority. At every arbitration point (IDLE pick, release, preempt), req[0] wins if set, else normal round-robin applies. Does not preempt a current owner before the hold limit. The hold limit still applies to source 0, and ptr is updated normally.
- Undefined: pure round-robin as above; all four sources are equal.

Decomposition:
- Package mux4_arb_pkg:
  - NUM_REQ=4, SEL_W=2.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - function onehot(idx) returning 4 bits.
- Sub-module rr_pick:
  - Combinational; inputs req[3:0], mask[3:0], ptr[1:0].
  - Outputs found and idx[1:0].
  - Instantiated once; the release/preempt mask excludes the owner.

Test Plan:
- Reset then req=0100 -> after 1 edge grant=0100, sel=10, valid=1; hold req 10 cycles with no others -> grant unchanged.
- req=1111 from IDLE with ptr=0, each owner drops its req after 1 cycle of grant -> grant sequence 0001, 0010, 0100, 1000 with no idle cycles; then req=0 -> grant=0000, valid=0.
- MAX_HOLD=8, req=0011 held constant -> source 0 holds 8 cycles, then grant=0010 for 8 cycles, then 0001; rotation repeats.
- Wrap: owner=3 releases while req=0011 -> next grant=0001 (ptr wrapped to 0), sel=00.
- Assert rst during GRANT with req=1111 -> next edge grant=0000, sel=00, valid=0; after rst drops, first grant=0001.
- With MUX4_ARB_PRIO_EN: owner=2 releases, req=1011 -> grant=0001, not 1000. Without the macro, the same stimulus gives grant=1000.
